win_tiler: RTL and testbench
============================

WIN_TILER -- requirements
Module: win_tiler

Interface
REQ-001 SHALL have parameter DW, default 10: sample width, signed two's complement.
REQ-002 SHALL have parameter TILE, default 9: samples per output tile.
REQ-003 SHALL have parameter STRIDE, default 7: new samples per tile after the first; OVERLAP = TILE-STRIDE = 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, DW: serial sample.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_last, input, 1: the sample is the last of its row/frame.
REQ-009 SHALL have port in_ready, output, 1: sample accepted when in_valid and in_ready.
REQ-010 SHALL have port D, output, DW*TILE: tile; sample 0 in D[DW*TILE-1 -: DW], sample 8 in D[DW-1:0]; drives the Winograd core D input.
REQ-011 SHALL have port tile_valid, output, 1: D holds a complete tile.
REQ-012 SHALL have port tile_ready, input, 1: consumer takes the tile when tile_valid and tile_ready.
REQ-013 SHALL have port tile_last, output, 1: qualifies tile_valid; tile closes a frame.
REQ-014 SHALL have port tile_count, output, 16: tiles emitted since reset; wraps at 65535 -> 0.

Function
REQ-015 SHALL have two states: FILL (in_ready=1, tile_valid=0) and HOLD (in_ready=0, tile_valid=1).
REQ-016 SHALL, in FILL, write each accepted sample into slot cnt and increment cnt (0..8).
REQ-017 SHALL go to HOLD on the cycle after the sample written to slot 8 is accepted, with tile_last = in_last of that sample.
REQ-018 SHALL, when in_last is accepted at slot k<8, zero slots k+1..8 and enter HOLD with tile_last=1.
REQ-019 SHALL hold D, tile_valid and tile_last stable in HOLD until the tile_ready handshake, for any number of stall cycles.
REQ-020 SHALL, on handshake with tile_last=0, copy slots 7,8 to slots 0,1, set cnt=2 and return to FILL.
REQ-021 SHALL, on handshake with tile_last=1, discard the overlap, set cnt=0 and return to FILL; the next frame starts with a full 9-sample fill.
REQ-022 SHALL increment tile_count by 1 on every tile handshake.
REQ-023 SHALL pass samples bit-exact, without sign extension, saturation or reordering.
REQ-024 SHALL have a tile latency of exactly 1 cycle: tile_valid rises on the cycle after the completing sample is accepted.
REQ-025 SHALL ignore in_valid, in_data and in_last while in_ready=0.
REQ-026 SHALL ignore tile_ready when tile_valid=0.
REQ-027 SHALL emit no tile and no count change for an in_last with no sample, which is impossible because in_last is qualified by in_valid.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set state=FILL, cnt=0, all slots=0, tile_valid=0, tile_last=0 and tile_count=0.
REQ-029 SHALL hold in_ready at 0 while rst=1 and at 1 from the first cycle after rst deasserts.
REQ-030 SHALL, on reset mid-fill or in HOLD, drop the partial or pending tile entirely; no stale sample appears in any later tile.

Structure
REQ-031 SHALL take DW, TILE, STRIDE, OVERLAP and the FILL/HOLD encoding from shared package win_pkg, which the core and the post-transform stage also use.
REQ-032 SHALL be a single flat module with no sub-modules: slot register array, cnt, 1-bit state, 16-bit counter.

Verification
REQ-033 SHALL check: stream 2,-10,3,4,-13,-18,-16,-28,-11 with tile_ready=1 -> D = 0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101, tile_valid 1 cycle after the 9th sample, tile_count=1.
REQ-034 SHALL check: stream 1..16 without last -> tile1 = {1..9}, tile2 = {8..16}, both tile_last=0, tile_count=2.
REQ-035 SHALL check: tile_ready low 5 cycles in HOLD while in_valid=1 -> D stable, in_ready=0, no sample lost; after release the following tile is correct.
REQ-036 SHALL check: samples 1..5, in_last on 5 -> {1,2,3,4,5,0,0,0,0}, tile_last=1; then 9 samples 21..29 -> {21..29} with no carried overlap.
REQ-037 SHALL check: rst pulse after 4 of 9 samples -> tile_valid=0 and tile_count=0; the next 9 samples 40..48 -> {40..48}.
REQ-038 SHALL check: force tile_count=65535 via 65536 tiles or preload -> wraps to 0 on the next handshake.

Source files
------------

// File: rtl/win_pkg.sv
// Shared tiling geometry and FILL/HOLD encoding for the Winograd input path.
package win_pkg;

  localparam int DW      = 10;
  localparam int TILE    = 9;
  localparam int STRIDE  = 7;
  localparam int OVERLAP = TILE - STRIDE;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/win_tiler.sv
// Cuts a serial sample stream into overlapping TILE-sample tiles for the Winograd core.
// Latency: tile valid 1 cycle after the completing sample; in_ready low while a tile is held.
module win_tiler #(
  parameter int DW     = win_pkg::DW,
  parameter int TILE   = win_pkg::TILE,
  parameter int STRIDE = win_pkg::STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [DW*TILE-1:0] D,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic               tile_last,
  output logic [15:0]        tile_count
);
  import win_pkg::*;

  localparam int OVL = TILE - STRIDE;
  localparam int CW  = $clog2(TILE);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] slot [TILE];
  logic [CW-1:0] cnt;
  logic          last_q;
  logic          accept;
  logic          handoff;
  logic          closing;

  assign in_ready   = (state == FILL) && !rst;
  assign tile_valid = (state == HOLD);
  assign tile_last  = last_q;
  assign accept     = in_valid && in_ready;
  assign handoff    = tile_valid && tile_ready;
  // A tile closes either on the final slot or early on a frame end.
  assign closing    = accept && (in_last || (cnt == CW'(TILE - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (closing) state_nxt = HOLD;
      HOLD:    if (handoff) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      last_q     <= 1'b0;
      tile_count <= '0;
      for (int i = 0; i < TILE; i++) begin
        slot[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < TILE; i++) begin
        if (CW'(i) == cnt) begin
          slot[i] <= in_data;
        end else if (in_last && (CW'(i) > cnt)) begin
          slot[i] <= '0;
        end
      end
      if (closing) begin
        last_q <= in_last;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (handoff) begin
      tile_count <= tile_count + 16'd1;
      last_q     <= 1'b0;
      // Frame end drops the overlap so the next frame starts clean.
      if (last_q) begin
        cnt <= '0;
      end else begin
        for (int i = 0; i < OVL; i++) begin
          slot[i] <= slot[i + STRIDE];
        end
        cnt <= CW'(OVL);
      end
    end
  end

  always_comb begin
    D = '0;
    for (int i = 0; i < TILE; i++) begin
      D[DW*(TILE-i)-1 -: DW] = slot[i];
    end
  end

endmodule

// File: tb/tb_win_tiler.sv
// Directed and randomized check of win_tiler against a sliding-window reference model.
module tb_win_tiler;

  localparam int DW     = 10;
  localparam int TILE   = 9;
  localparam int STRIDE = 7;
  localparam int OV     = TILE - STRIDE;
  localparam int TW     = DW * TILE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [TW-1:0] D;
  logic          tile_valid;
  logic          tile_ready = 1'b0;
  logic          tile_last;
  logic [15:0]   tile_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   exp_count = '0;
  logic [DW-1:0] fr [$];
  logic [TW-1:0] last_d = '0;
  int            s33 [9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
  logic [TW-1:0] lit33 = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101;

  win_tiler #(.DW(DW), .TILE(TILE), .STRIDE(STRIDE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .D         (D),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_last (tile_last),
    .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    tile_ready = 1'b0;
    step();
    chk_b({tag, "_rst_in_ready"}, in_ready, 1'b0);
    chk_b({tag, "_rst_tile_valid"}, tile_valid, 1'b0);
    chk_b({tag, "_rst_tile_last"}, tile_last, 1'b0);
    chk_c({tag, "_rst_count"}, tile_count, 16'd0);
    rst = 1'b0;
    exp_count = '0;
    #1;
    chk_b({tag, "_post_rst_in_ready"}, in_ready, 1'b1);
  endtask

  // Reference: tile m covers stream indices STRIDE*m .. STRIDE*m+TILE-1, zero-padded past
  // a frame end; it is due once its last index arrives or the frame ends inside it.
  task automatic run_frame(input string tag, input int n, input bit has_last, input int stall);
    logic [TW-1:0] ed [$];
    bit            el [$];
    int            ea [$];
    logic [TW-1:0] t;
    int            start;
    int            fin;
    int            ns;
    for (int m = 0; m <= n; m++) begin
      start = STRIDE * m;
      if (start + TILE - 1 <= n - 1) fin = start + TILE - 1;
      else if (has_last && (m == 0 || start + OV <= n - 1)) fin = n - 1;
      else break;
      t = '0;
      for (int i = 0; i < TILE; i++) begin
        if (start + i < n) t[TW-1-DW*i -: DW] = fr[start + i];
      end
      ed.push_back(t);
      el.push_back(has_last && (fin == n - 1));
      ea.push_back(fin);
      if (has_last && (fin == n - 1)) break;
    end

    for (int j = 0; j < n; j++) begin
      in_valid   = 1'b1;
      in_data    = fr[j];
      in_last    = has_last && (j == n - 1);
      tile_ready = 1'($urandom_range(1, 0));
      chk_b({tag, "_in_ready"}, in_ready, 1'b1);
      step();
      in_valid   = 1'b0;
      in_last    = 1'b0;
      tile_ready = 1'b0;
      if (ea.size() > 0 && ea[0] == j) begin
        chk_b({tag, "_tile_valid"}, tile_valid, 1'b1);
        chk_d({tag, "_D"}, D, ed[0]);
        chk_b({tag, "_tile_last"}, tile_last, el[0]);
        chk_b({tag, "_hold_in_ready"}, in_ready, 1'b0);
        ns = (stall >= 0) ? stall : $urandom_range(3, 0);
        for (int s = 0; s < ns; s++) begin
          in_valid = 1'b1;
          in_data  = DW'($urandom);
          in_last  = 1'($urandom);
          step();
          chk_d({tag, "_stall_D"}, D, ed[0]);
          chk_b({tag, "_stall_in_ready"}, in_ready, 1'b0);
          chk_b({tag, "_stall_last"}, tile_last, el[0]);
        end
        last_d     = D;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
        exp_count  = exp_count + 16'd1;
        chk_c({tag, "_count"}, tile_count, exp_count);
        chk_b({tag, "_released"}, tile_valid, 1'b0);
        void'(ed.pop_front());
        void'(el.pop_front());
        void'(ea.pop_front());
      end else begin
        chk_b({tag, "_no_tile"}, tile_valid, 1'b0);
      end
    end
  endtask

  initial begin
    int n;

    do_reset("init");

    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(DW'(s33[i]));
    run_frame("seq9", 9, 1'b0, 0);
    chk_d("seq9_literal", last_d, lit33);
    chk_c("seq9_total", tile_count, 16'd1);
    do_reset("r1");

    fr.delete();
    for (int i = 1; i <= 16; i++) fr.push_back(DW'(i));
    run_frame("ramp16", 16, 1'b0, 0);
    chk_c("ramp16_total", tile_count, 16'd2);
    do_reset("r2");

    fr.delete();
    for (int i = 0; i < 16; i++) fr.push_back(DW'(100 + i));
    run_frame("stall5", 16, 1'b1, 5);

    fr.delete();
    for (int i = 1; i <= 5; i++) fr.push_back(DW'(i));
    run_frame("short5", 5, 1'b1, 1);
    fr.delete();
    for (int i = 21; i <= 29; i++) fr.push_back(DW'(i));
    run_frame("after_short", 9, 1'b1, 0);

    fr.delete();
    for (int i = 30; i < 34; i++) fr.push_back(DW'(i));
    run_frame("partial", 4, 1'b0, 0);
    do_reset("mid_fill");
    fr.delete();
    for (int i = 40; i <= 48; i++) fr.push_back(DW'(i));
    run_frame("post_rst", 9, 1'b1, 0);

    force dut.tile_count = 16'hFFFF;
    step();
    release dut.tile_count;
    exp_count = 16'hFFFF;
    step();
    chk_c("wrap_preload", tile_count, 16'hFFFF);
    fr.delete();
    fr.push_back(DW'(7));
    run_frame("wrap", 1, 1'b1, 0);
    chk_c("wrap_zero", tile_count, 16'd0);

    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(25, 1);
      fr.delete();
      for (int i = 0; i < n; i++) fr.push_back(DW'($urandom));
      run_frame("rand", n, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
